// File: rtl/clk_div_multi.sv
// clk_div_multi: multi-channel programmable clock divider with tick strobes and phase sync
//   clk_50MHz  in   system clock, rising edge
//   reset      in   asynchronous active-high reset
//   en         in   [NUM_CH] per-channel run enable
//   sync       in   restart all running channels in phase
//   cfg_load   in   [NUM_CH] write cfg_div/cfg_high into the channel's shadow registers
//   cfg_div    in   [CNT_W] requested period
//   cfg_high   in   [CNT_W] requested high time
//   clk_out    out  [NUM_CH] divided clocks
//   tick       out  [NUM_CH] strobe in the last input cycle of each period
//   running    out  [NUM_CH] channel active status
module clk_div_multi #(
    parameter int NUM_CH   = 4,
    parameter int CNT_W    = 20,
    parameter int DEF_DIV  = 500000,
    parameter int DEF_HIGH = 250000
) (
    input  logic              clk_50MHz,
    input  logic              reset,
    input  logic [NUM_CH-1:0] en,
    input  logic              sync,
    input  logic [NUM_CH-1:0] cfg_load,
    input  logic [CNT_W-1:0]  cfg_div,
    input  logic [CNT_W-1:0]  cfg_high,
    output logic [NUM_CH-1:0] clk_out,
    output logic [NUM_CH-1:0] tick,
    output logic [NUM_CH-1:0] running
);
    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        logic [CNT_W-1:0] r_sh_div, r_sh_high, r_div, r_high, r_cnt;
        logic             r_clk, r_tick, r_run;
        logic [CNT_W-1:0] w_peff, w_last, w_heff;
        logic [CNT_W:0]   w_nxt;
        logic             w_restart;
        // clamp so every period has at least one high and one low cycle
        assign w_peff    = (r_div < CNT_W'(2)) ? CNT_W'(2) : r_div;
        assign w_last    = w_peff - CNT_W'(1);
        assign w_heff    = (r_high == '0) ? CNT_W'(1) : (r_high > w_last) ? w_last : r_high;
        assign w_nxt     = {1'b0, r_cnt} + (CNT_W+1)'(1);
        assign w_restart = !r_run || sync || (r_cnt == w_last);
        always_ff @(posedge clk_50MHz or posedge reset) begin
            if (reset) begin
                r_sh_div  <= CNT_W'(DEF_DIV);
                r_sh_high <= CNT_W'(DEF_HIGH);
            end else if (cfg_load[g]) begin
                r_sh_div  <= cfg_div;
                r_sh_high <= cfg_high;
            end
        end
        // active values only change at a period boundary, taking the pre-edge shadow
        always_ff @(posedge clk_50MHz or posedge reset) begin
            if (reset) begin
                r_div  <= CNT_W'(DEF_DIV);
                r_high <= CNT_W'(DEF_HIGH);
                r_cnt  <= '0;
                r_clk  <= 1'b0;
                r_tick <= 1'b0;
                r_run  <= 1'b0;
            end else if (!en[g]) begin
                r_cnt  <= '0;
                r_clk  <= 1'b0;
                r_tick <= 1'b0;
                r_run  <= 1'b0;
            end else if (w_restart) begin
                r_div  <= r_sh_div;
                r_high <= r_sh_high;
                r_cnt  <= '0;
                r_clk  <= 1'b1;
                r_tick <= 1'b0;
                r_run  <= 1'b1;
            end else begin
                r_cnt  <= w_nxt[CNT_W-1:0];
                r_clk  <= w_nxt < {1'b0, w_heff};
                r_tick <= w_nxt == {1'b0, w_last};
            end
        end
        assign clk_out[g] = r_clk;
        assign tick[g]    = r_tick;
        assign running[g] = r_run;
    end
endmodule

// File: tb/tb_clk_div_multi.sv
// tb_clk_div_multi: randomized and directed checks of clk_div_multi against a phase-based model
module tb_clk_div_multi;
    localparam int N = 2;
    localparam int W = 8;
    logic         clk_50MHz = 1'b0;
    logic         reset = 1'b0;
    logic         sync = 1'b0;
    logic [N-1:0] en = '0;
    logic [N-1:0] cfg_load = '0;
    logic [W-1:0] cfg_div = '0;
    logic [W-1:0] cfg_high = '0;
    logic [N-1:0] clk_out, tick, running;
    int n_chk = 0;
    int n_fail = 0;
    bit chk_on = 1'b0;
    int m_run[N], m_k[N], m_p[N], m_h[N], m_sp[N], m_sh[N];

    clk_div_multi #(.NUM_CH(N), .CNT_W(W), .DEF_DIV(10), .DEF_HIGH(3)) dut (
        .clk_50MHz(clk_50MHz), .reset(reset), .en(en), .sync(sync),
        .cfg_load(cfg_load), .cfg_div(cfg_div), .cfg_high(cfg_high),
        .clk_out(clk_out), .tick(tick), .running(running)
    );

    always #10 clk_50MHz = ~clk_50MHz;

    function automatic int peff(int p);
        return p < 2 ? 2 : p;
    endfunction

    function automatic int heff(int h, int p);
        return h < 1 ? 1 : (h > peff(p) - 1 ? peff(p) - 1 : h);
    endfunction

    task automatic chk(string nm, int act, int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // model: each running channel sits at phase k of a period of length Peff
    always @(posedge clk_50MHz or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < N; i++) begin
                m_run[i] = 0; m_k[i] = 0;
                m_p[i] = 10; m_h[i] = 3; m_sp[i] = 10; m_sh[i] = 3;
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                if (!en[i]) begin
                    m_run[i] = 0; m_k[i] = 0;
                end else if (m_run[i] == 0 || sync || m_k[i] == peff(m_p[i]) - 1) begin
                    m_run[i] = 1; m_k[i] = 0; m_p[i] = m_sp[i]; m_h[i] = m_sh[i];
                end else begin
                    m_k[i] = m_k[i] + 1;
                end
                if (cfg_load[i]) begin
                    m_sp[i] = int'(cfg_div); m_sh[i] = int'(cfg_high);
                end
            end
        end
    end

    always @(posedge clk_50MHz) begin
        #1;
        if (chk_on) begin
            logic [N-1:0] ec, et, er;
            for (int i = 0; i < N; i++) begin
                er[i] = m_run[i] != 0;
                ec[i] = er[i] && m_k[i] < heff(m_h[i], m_p[i]);
                et[i] = er[i] && m_k[i] == peff(m_p[i]) - 1;
            end
            chk("model_clk_out", int'(clk_out), int'(ec));
            chk("model_tick", int'(tick), int'(et));
            chk("model_running", int'(running), int'(er));
        end
    end

    task automatic load(logic [N-1:0] m, int p, int h);
        @(negedge clk_50MHz);
        cfg_load = m; cfg_div = W'(p); cfg_high = W'(h);
        @(negedge clk_50MHz);
        cfg_load = '0;
    endtask

    task automatic tick_wait(int ch);
        int i;
        for (i = 0; i < 100; i++) begin
            @(posedge clk_50MHz); #1;
            if (tick[ch]) break;
        end
        if (i == 100) begin
            n_chk++; n_fail++;
            $display("FAIL tick_wait ch%0d: got no tick expected tick within 100 cycles", ch);
        end
    endtask

    task automatic pattern(string nm, int ch, int n, logic [31:0] exp_c, logic [31:0] exp_t);
        logic [31:0] gc = '0, gt = '0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk_50MHz); #1;
            gc = {gc[30:0], clk_out[ch]};
            gt = {gt[30:0], tick[ch]};
        end
        chk({nm, "_clk"}, int'(gc), int'(exp_c));
        chk({nm, "_tick"}, int'(gt), int'(exp_t));
    endtask

    initial begin
        #5 reset = 1'b1;
        chk_on = 1'b1;
        #20;
        chk("reset_clk_out", int'(clk_out), 0);
        chk("reset_running", int'(running), 0);
        @(negedge clk_50MHz) reset = 1'b0;
        @(negedge clk_50MHz) en = 2'b01;
        pattern("ch0_default", 0, 20, 32'b11100000001110000000, 32'b00000000010000000001);
        chk("ch1_idle", int'(clk_out[1] | running[1] | tick[1]), 0);
        repeat (4) @(negedge clk_50MHz);
        load(2'b01, 6, 4);
        tick_wait(0);
        pattern("ch0_reload", 0, 12, 32'b111100111100, 32'b000001000001);
        load(2'b01, 0, 5);
        tick_wait(0);
        pattern("p0", 0, 4, 32'b1010, 32'b0101);
        load(2'b01, 1, 0);
        tick_wait(0);
        pattern("p1", 0, 4, 32'b1010, 32'b0101);
        load(2'b01, 6, 0);
        tick_wait(0);
        pattern("h0", 0, 6, 32'b100000, 32'b000001);
        load(2'b01, 5, 9);
        tick_wait(0);
        pattern("h_ge_p", 0, 5, 32'b11110, 32'b00001);
        @(negedge clk_50MHz) en = 2'b11;
        repeat (5) @(negedge clk_50MHz);
        load(2'b11, 7, 2);
        repeat (3) @(negedge clk_50MHz);
        sync = 1'b1;
        @(posedge clk_50MHz); #1;
        chk("sync_clk_out", int'(clk_out), 3);
        chk("sync_tick", int'(tick), 0);
        @(negedge clk_50MHz) sync = 1'b0;
        pattern("sync_ch0", 0, 7, 32'b1000001, 32'b0000010);
        pattern("sync_ch1", 1, 7, 32'b1000001, 32'b0000010);
        @(negedge clk_50MHz) en = 2'b10;
        @(posedge clk_50MHz); #1;
        chk("en_drop_clk", int'(clk_out[0]), 0);
        chk("en_drop_running", int'(running[0]), 0);
        @(negedge clk_50MHz) en = 2'b11;
        pattern("restart", 0, 7, 32'b1100000, 32'b0000001);
        @(negedge clk_50MHz);
        #3 reset = 1'b1;
        #1;
        chk("async_reset_clk_out", int'(clk_out), 0);
        chk("async_reset_running", int'(running), 0);
        @(negedge clk_50MHz) reset = 1'b0;
        pattern("post_reset", 0, 10, 32'b1110000000, 32'b0000000001);
        for (int c = 0; c < 800; c++) begin
            @(negedge clk_50MHz);
            en = ($urandom_range(0, 19) == 0) ? N'($urandom) : en;
            sync = $urandom_range(0, 29) == 0;
            cfg_load = ($urandom_range(0, 5) == 0) ? N'($urandom) : '0;
            cfg_div = W'($urandom_range(0, 12));
            cfg_high = W'($urandom_range(0, 14));
        end
        @(negedge clk_50MHz);
        sync = 1'b0; cfg_load = '0;
        @(negedge clk_50MHz);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
